sisc_fetch: RTL and testbench
=============================

# sisc_fetch

Instruction fetch and branch-resolution unit of the SISC computer. Holds the program counter (PC) and instruction register (IR), fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents decoded fields (opcode, mm, register indices, immediate) to the control FSM and datapath. On the controller's command it evaluates the status flags and redirects the PC for BRA/BRR/BNE/BNR.

## Interface
- TIMEOUT, 15: cycles without imem_ack before a fetch aborts (used only with SISC_FETCH_TIMEOUT_EN)
- clk  in  1  clock; all state updates on rising edge
- rst_f  in  1  reset, asynchronous, active-low
- fetch_go  in  1  one-cycle pulse from controller: start a fetch at the current PC
- br_go  in  1  one-cycle pulse from controller: resolve the branch held in IR
- stat  in  4  status flags (C,N,V,Z) from status register
- imem_req  out  1  registered fetch request, held until acknowledged
- imem_addr  out  16  registered fetch address (equals PC while imem_req is high)
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- opcode, mm, rd, rs, rt  out  4 each  IR[31:28], IR[27:24], IR[23:20], IR[19:16], IR[15:12]
- imm  out  16  IR[15:0]
- pc  out  16  current PC
- ir_valid  out  1  IR holds a completed fetch not yet superseded
- busy  out  1  fetch in progress
- br_taken  out  1  one-cycle pulse: branch taken, PC redirected
- fetch_err  out  1  sticky abort flag (SISC_FETCH_TIMEOUT_EN only; tied 0 otherwise)

## Operation
- States: IDLE, FETCH, READY.
- Reset (asynchronous): state IDLE, PC=0, IR=0 (NOOP), imem_req=0, imem_addr=0, ir_valid=0, busy=0, br_taken=0, fetch_err=0, timeout counter=0.
- IDLE or READY, fetch_go=1 -> FETCH; imem_req=1, imem_addr=PC from next cycle; ir_valid cleared; busy=1.
- FETCH: imem_ack=1 -> IR<=imem_rdata, PC<=PC+1 (16-bit wrap, 16'hFFFF->0), imem_req<=0, ir_valid<=1, -> READY.
- fetch_go in FETCH ignored. imem_ack while imem_req=0 ignored.
- READY, br_go=1 with opcode in {BRA=4, BRR=5, BNE=6, BNR=7}: condition evaluated on current stat.
  - BRA/BRR taken if (stat & mm) != 0 or mm == 0.
  - BNE/BNR taken if (stat & mm) == 0.
  - Absolute (BRA, BNE): PC <= imm. Relative (BRR, BNR): PC <= PC + imm, modulo 2^16 (PC already points to next instruction).
  - Taken: br_taken pulses one cycle. Not taken: PC unchanged, no pulse.
- br_go with any other opcode, or outside READY: no effect.
- br_go and fetch_go same cycle in READY: PC updated by branch first; the fetch issues at the branch target.
- Decoded field outputs are combinational from IR and stable between fetches.

## Timing
- fetch_go at edge N -> imem_req, imem_addr valid after edge N+1.
- Zero-wait memory (ack in first request cycle): IR, ir_valid, PC+1 visible after edge N+2. Each wait cycle adds one.
- br_go at edge M -> new PC and br_taken visible after edge M+1; br_taken low after M+2.
- Reset mid-fetch drops imem_req immediately; ack arriving during or after reset is ignored.

## Configuration
- SISC_FETCH_TIMEOUT_EN defined: counter runs in FETCH; after TIMEOUT consecutive cycles without imem_ack, imem_req drops, IR<=0 (NOOP), PC unchanged, fetch_err set (sticky until reset), -> READY with ir_valid=1. Counter clears on entering FETCH.
- Not defined: no counter; FETCH waits indefinitely; fetch_err tied 0.

## Test plan
- Reset then fetch_go, memory returns 32'h8012_3000 with ack in first cycle -> req high 1 cycle at addr 0, opcode=8, mm=0, rd=1, rs=2, rt=3, pc=1, ir_valid=1 two cycles after fetch_go.
- Ack delayed 3 cycles -> req/addr held stable 4 cycles, extra fetch_go pulses ignored, single IR load.
- IR=BRR (32'h5400_FFFE, mm=4), pc=10, stat=4'b0100, br_go -> pc=8, br_taken one-cycle pulse; same with stat=0 -> pc stays 10, no pulse.
- IR=BNE (32'h6100_0040, mm=1), stat=4'b0000, br_go and fetch_go same cycle -> pc=16'h0040, next imem_addr=16'h0040.
- PC=16'hFFFF, fetch completes -> pc=0. rst_f low during wait cycle -> imem_req=0 at once, later ack leaves IR=0, pc=0.
- With SISC_FETCH_TIMEOUT_EN, TIMEOUT=15, no ack -> req drops after 15 cycles, opcode=0, fetch_err=1, ir_valid=1.

Source files
------------

// File: rtl/sisc_fetch.sv
// SISC instruction fetch and branch-resolution unit: PC/IR, imem req/ack fetch, decoded fields.
// Optional fetch timeout abort enabled by defining SISC_FETCH_TIMEOUT_EN.
module sisc_fetch
`ifdef SISC_FETCH_TIMEOUT_EN
#(
  parameter int TIMEOUT = 15
)
`endif
(
  input  logic        clk,
  input  logic        rst_f,
  input  logic        fetch_go,
  input  logic        br_go,
  input  logic [3:0]  stat,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [3:0]  opcode,
  output logic [3:0]  mm,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [15:0] imm,
  output logic [15:0] pc,
  output logic        ir_valid,
  output logic        busy,
  output logic        br_taken,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_READY = 2'd2
  } state_e;

  localparam logic [3:0] OP_BRA = 4'd4;
  localparam logic [3:0] OP_BRR = 4'd5;
  localparam logic [3:0] OP_BNE = 4'd6;
  localparam logic [3:0] OP_BNR = 4'd7;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        br_taken_q, br_taken_d;

`ifdef SISC_FETCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
`endif

  // Decoded fields straight from IR.
  assign opcode = ir_q[31:28];
  assign mm     = ir_q[27:24];
  assign rd     = ir_q[23:20];
  assign rs     = ir_q[19:16];
  assign rt     = ir_q[15:12];
  assign imm    = ir_q[15:0];

  // Branch condition and target for the instruction held in IR.
  logic        cond_hit;
  logic        br_take;
  logic [15:0] br_target;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    cond_hit  = (stat & mm) != 4'd0;
    br_take   = 1'b0;
    br_target = pc_q;
    case (opcode)
      OP_BRA: begin
        br_take   = cond_hit || (mm == 4'd0);
        br_target = imm;
      end
      OP_BRR: begin
        br_take   = cond_hit || (mm == 4'd0);
        br_target = pc_q + imm;
      end
      OP_BNE: begin
        br_take   = !cond_hit;
        br_target = imm;
      end
      OP_BNR: begin
        br_take   = !cond_hit;
        br_target = pc_q + imm;
      end
      default: ;
    endcase
  end

  logic        start_fetch;
  logic [15:0] pc_br;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    req_d       = req_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    br_taken_d  = 1'b0;
    start_fetch = 1'b0;
    pc_br       = pc_q;
`ifdef SISC_FETCH_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        start_fetch = fetch_go;
      end
      S_READY: begin
        // Branch resolves before a same-cycle fetch, so the fetch goes to the target.
        if (br_go && br_take) begin
          pc_br      = br_target;
          br_taken_d = 1'b1;
        end
        pc_d        = pc_br;
        start_fetch = fetch_go;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + 16'd1;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_READY;
        end
`ifdef SISC_FETCH_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          ir_d    = 32'd0;
          req_d   = 1'b0;
          valid_d = 1'b1;
          err_d   = 1'b1;
          state_d = S_READY;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (start_fetch) begin
      state_d = S_FETCH;
      req_d   = 1'b1;
      addr_d  = pc_br;
      valid_d = 1'b0;
`ifdef SISC_FETCH_TIMEOUT_EN
      tmo_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= S_IDLE;
      pc_q       <= 16'd0;
      ir_q       <= 32'd0;
      req_q      <= 1'b0;
      addr_q     <= 16'd0;
      valid_q    <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      br_taken_q <= br_taken_d;
    end
  end

`ifdef SISC_FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign pc        = pc_q;
  assign ir_valid  = valid_q;
  assign busy      = (state_q == S_FETCH);
  assign br_taken  = br_taken_q;

endmodule

// File: tb/tb_sisc_fetch.sv
// Self-checking bench for sisc_fetch: directed cases plus randomized fetch/branch traffic
// compared against a transaction-level model of PC, IR and ir_valid.
module tb_sisc_fetch;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        fetch_go, br_go, imem_ack;
  logic [3:0]  stat;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [3:0]  opcode, mm, rd, rs, rt;
  logic [15:0] imm, pc;
  logic        ir_valid, busy, br_taken, fetch_err;

  sisc_fetch dut (
    .clk(clk), .rst_f(rst_f), .fetch_go(fetch_go), .br_go(br_go), .stat(stat),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm), .pc(pc),
    .ir_valid(ir_valid), .busy(busy), .br_taken(br_taken), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural view only.
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic        m_valid;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input string tag);
    check({tag, ".pc"},       pc,        m_pc);
    check({tag, ".opcode"},   opcode,    m_ir[31:28]);
    check({tag, ".mm"},       mm,        m_ir[27:24]);
    check({tag, ".rd"},       rd,        m_ir[23:20]);
    check({tag, ".rs"},       rs,        m_ir[19:16]);
    check({tag, ".rt"},       rt,        m_ir[15:12]);
    check({tag, ".imm"},      imm,       m_ir[15:0]);
    check({tag, ".ir_valid"}, ir_valid,  m_valid);
    check({tag, ".fetch_err"}, fetch_err, m_err);
  endtask

  function automatic void model_branch(input logic [31:0] ir, input logic [15:0] cur_pc,
                                       input logic [3:0] s, output bit tk, output logic [15:0] tgt);
    int          op   = int'(ir[31:28]);
    logic [3:0]  mask = ir[27:24];
    logic [15:0] im   = ir[15:0];
    bit          any  = (s & mask) != 4'd0;
    tk  = 1'b0;
    tgt = cur_pc;
    if (op == 4 || op == 5) tk = any || (mask == 4'd0);
    else if (op == 6 || op == 7) tk = !any;
    if (op == 4 || op == 6) tgt = im;
    else tgt = 16'((32'(cur_pc) + 32'(im)) % 65536);
  endfunction

  // Called one cycle after fetch_go was sampled; waits, acks, checks the load.
  task automatic wait_and_ack(input int waits, input logic [31:0] word, input bit extra_go);
    logic [15:0] a;
    a = m_pc;
    check("req_on", imem_req, 1);
    check("addr", imem_addr, a);
    check("busy_on", busy, 1);
    check("valid_clr", ir_valid, 0);
    for (int i = 0; i < waits; i++) begin
      fetch_go = extra_go;
      imem_ack = 1'b0;
      tick();
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, a);
    end
    fetch_go   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    m_ir    = word;
    m_pc    = m_pc + 16'd1;
    m_valid = 1'b1;
    check("req_off", imem_req, 0);
    check("busy_off", busy, 0);
    check_fields("fetch");
  endtask

  task automatic fetch(input int waits, input logic [31:0] word, input bit extra_go);
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    wait_and_ack(waits, word, extra_go);
  endtask

  task automatic branch(input logic [3:0] s, input bit with_fetch, input logic [31:0] next_word,
                        input int waits);
    bit          tk;
    logic [15:0] tgt;
    model_branch(m_ir, m_pc, s, tk, tgt);
    tk = tk && m_valid;  // branches resolve only while an instruction is ready
    stat     = s;
    br_go    = 1'b1;
    fetch_go = with_fetch;
    tick();
    br_go    = 1'b0;
    fetch_go = 1'b0;
    if (tk) m_pc = tgt;
    check("br_taken", br_taken, tk);
    check("br_pc", pc, m_pc);
    if (with_fetch) begin
      m_valid = 1'b0;
      wait_and_ack(waits, next_word, 1'b0);
    end else begin
      tick();
      check("br_pulse_end", br_taken, 0);
      check_fields("after_br");
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 1) w[31:28] = 4'($urandom_range(4, 7));
    return w;
  endfunction

  initial begin
    rst_f = 1'b0; fetch_go = 1'b0; br_go = 1'b0; imem_ack = 1'b0;
    stat = 4'd0; imem_rdata = 32'd0;
    m_pc = 16'd0; m_ir = 32'd0; m_valid = 1'b0; m_err = 1'b0;
    tick(); tick();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_br_taken", br_taken, 0);
    check_fields("rst");
    rst_f = 1'b1;
    tick();

    // Branch and stray ack in IDLE have no effect.
    branch(4'hF, 1'b0, 32'd0, 0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check_fields("idle_ack");
    check("idle_ack_req", imem_req, 0);

    fetch(0, 32'h8012_3000, 1'b0);
    // Delayed ack with extra fetch_go pulses; BRA mm=0 jumps to 9.
    fetch(3, 32'h4000_0009, 1'b1);
    branch(4'($urandom_range(0, 15)), 1'b0, 32'd0, 0);
    check("bra_pc9", pc, 16'd9);
    fetch(0, 32'h5400_FFFE, 1'b0);
    check("brr_pc10", pc, 16'd10);
    branch(4'b0000, 1'b0, 32'd0, 0);
    check("brr_not_taken", pc, 16'd10);
    branch(4'b0100, 1'b0, 32'd0, 0);
    check("brr_taken", pc, 16'd8);

    fetch(1, 32'h6100_0040, 1'b0);
    branch(4'b0000, 1'b1, 32'h1234_5678, 0);
    check("bne_fetch_pc", pc, 16'h0041);
    branch(4'hF, 1'b0, 32'd0, 0);  // non-branch opcode

    fetch(0, 32'h4000_FFFF, 1'b0);
    branch(4'h3, 1'b0, 32'd0, 0);
    check("wrap_pre", pc, 16'hFFFF);
    fetch(2, 32'h0000_0000, 1'b0);
    check("wrap_post", pc, 16'h0000);

    for (int it = 0; it < 150; it++) begin
      fetch($urandom_range(0, 4), rand_word(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) != 0)
        branch(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rand_word(),
               $urandom_range(0, 3));
    end

`ifdef SISC_FETCH_TIMEOUT_EN
    begin
      int hi_cycles;
      logic [15:0] a;
      a = m_pc;
      hi_cycles = 0;
      fetch_go = 1'b1;
      tick();
      fetch_go = 1'b0;
      while (imem_req && hi_cycles < 40) begin
        check("tmo_addr", imem_addr, a);
        hi_cycles++;
        tick();
      end
      check("tmo_cycles", hi_cycles, 15);
      m_ir = 32'd0; m_valid = 1'b1; m_err = 1'b1;
      check_fields("tmo");
      fetch(0, 32'h8012_3000, 1'b0);  // flag stays sticky
    end
`endif

    // Reset during a wait cycle; the late ack must be ignored.
    fetch_go = 1'b1;
    tick();
    fetch_go = 1'b0;
    check("mid_req", imem_req, 1);
    tick();
    rst_f = 1'b0;
    #1;
    check("rst_drop_req", imem_req, 0);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    rst_f = 1'b1;
    tick();
    imem_ack = 1'b0;
    m_pc = 16'd0; m_ir = 32'd0; m_valid = 1'b0; m_err = 1'b0;
    check_fields("post_rst");
    check("post_rst_req", imem_req, 0);
    check("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
